// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring shift/subtract on operand magnitudes,
// one quotient bit per cycle, then a sign fix-up cycle. done pulses once per result.
module seq_signed_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   rem_q, quo_q, dvs_q;
  logic           sign_q, sign_r, zero_q;
  logic           accept;

  logic [N-1:0]   dd_mag, dv_mag;
  logic [N:0]     shifted, diff;
  logic           fits;

  // -2^(N-1) negates to itself, which read unsigned is exactly its magnitude.
  assign dd_mag = dividend[N-1] ? ({N{1'b0}} - dividend) : dividend;
  assign dv_mag = divisor[N-1]  ? ({N{1'b0}} - divisor)  : divisor;

  // The stored partial remainder stays below |divisor|, so after the shift the
  // N+1-bit difference is exact as a signed value and its MSB is the borrow.
  assign shifted = {rem_q, quo_q[N-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    accept = (state == IDLE) && start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_q      <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: if (accept) begin
          rem_q  <= '0;
          quo_q  <= dd_mag;
          dvs_q  <= dv_mag;
          sign_q <= dividend[N-1] ^ divisor[N-1];
          sign_r <= dividend[N-1];
          zero_q <= (divisor == '0);
          cnt    <= CW'(N);
        end
        RUN: begin
          rem_q <= fits ? diff[N-1:0] : shifted[N-1:0];
          quo_q <= {quo_q[N-2:0], fits};
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          // With a zero divisor the remainder path already yields |dividend|;
          // only the quotient needs forcing to -1.
          quotient    <= zero_q ? {N{1'b1}} : (sign_q ? ({N{1'b0}} - quo_q) : quo_q);
          remainder   <= sign_r ? ({N{1'b0}} - rem_q) : rem_q;
          div_by_zero <= zero_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed vector table, handshake and
// reset corner sequences, and randomized pairs against a plain-arithmetic model.
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  seq_signed_divider #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        dz;
  } vec_t;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncated back to 32 bits.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint la, lb;
    la = longint'(signed'(a));
    lb = longint'(signed'(b));
    if (lb == 0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else begin
      q = 32'(la / lb); r = 32'(la % lb); dz = 1'b0;
    end
  endtask

  // Called #1 after a rising edge with busy=0; returns at #1 after the done edge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  vec_t        vt[11];
  logic [31:0] q, r, eq, er;
  logic        dz, edz;
  int          lat;
  logic [31:0] ha[40], hb[40];
  int          early, done_at;

  initial begin
    vt[0]  = '{32'd553524,          32'd840,           32'd658,           32'd804,          1'b0};
    vt[1]  = '{32'(-553524),        32'd840,           32'(-658),         32'(-804),        1'b0};
    vt[2]  = '{32'd553524,          32'(-259),         32'(-2137),        32'd41,           1'b0};
    vt[3]  = '{32'(-259),           32'(-259),         32'd1,             32'd0,            1'b0};
    vt[4]  = '{32'd1234,            32'd0,             32'hFFFF_FFFF,     32'd1234,         1'b1};
    vt[5]  = '{32'd7,               32'd2,             32'd3,             32'd1,            1'b0};
    vt[6]  = '{32'h8000_0000,       32'hFFFF_FFFF,     32'h8000_0000,     32'd0,            1'b0};
    vt[7]  = '{32'h8000_0000,       32'd1,             32'h8000_0000,     32'd0,            1'b0};
    vt[8]  = '{32'(-7),             32'd0,             32'hFFFF_FFFF,     32'(-7),          1'b1};
    vt[9]  = '{32'(-1),             32'h8000_0000,     32'd0,             32'(-1),          1'b0};
    vt[10] = '{32'd5,               32'd7,             32'd0,             32'd5,            1'b0};

    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {39'd0, busy, done, div_by_zero, quotient, remainder},
        {39'd0, 3'b000, 64'd0});
    rst = 1'b1;
    @(posedge clk); #1;

    // First transaction by hand: busy on accept, latency, single-cycle done.
    dividend = 32'd553524; divisor = 32'd840; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'd1; divisor = 32'd1;
    chk("busy_after_accept", {70'd0, busy, done}, {70'd0, 2'b10});
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    chk("first_latency", 72'(lat), 72'd33);
    chk("first_result", {7'd0, busy, div_by_zero, quotient, remainder},
        {7'd0, 1'b0, 1'b0, 32'd658, 32'd804});
    @(posedge clk); #1;
    chk("done_one_cycle", {71'd0, done}, 72'd0);
    chk("result_held", {quotient, remainder}, {32'd658, 32'd804});
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_div(vt[i].a, vt[i].b, q, r, dz, lat);
      chk($sformatf("vec%0d_q", i),   72'(q),   72'(vt[i].q));
      chk($sformatf("vec%0d_r", i),   72'(r),   72'(vt[i].r));
      chk($sformatf("vec%0d_dz", i),  72'(dz),  72'(vt[i].dz));
      chk($sformatf("vec%0d_lat", i), 72'(lat), 72'd33);
    end

    // Start held for 40 cycles with changing operands; second accept lands on the done cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      ha[i] = 32'd1000 + 32'(i) * 32'd37;
      hb[i] = 32'(-3 - i);
    end
    early = 0;
    for (int i = 0; i < 40; i++) begin
      dividend = ha[i]; divisor = hb[i]; start = 1'b1;
      @(posedge clk); #1;
      if (i < 33 && done) early++;
      if (i == 33) begin
        model(ha[0], hb[0], eq, er, edz);
        chk("hs_first_done", {71'd0, done}, {71'd0, 1'b1});
        chk("hs_first_result", {quotient, remainder}, {eq, er});
      end
      if (i == 34) chk("hs_second_accepted", {71'd0, busy}, {71'd0, 1'b1});
    end
    start = 1'b0;
    chk("hs_no_early_done", 72'(early), 72'd0);
    done_at = -1;
    for (int j = 40; j < 120; j++) begin
      @(posedge clk); #1;
      if (done) begin done_at = j; break; end
    end
    model(ha[34], hb[34], eq, er, edz);
    chk("hs_second_latency", 72'(done_at), 72'd67);
    chk("hs_second_result", {quotient, remainder}, {eq, er});

    // Reset mid-operation.
    @(posedge clk); #1;
    dividend = 32'd999; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_outputs", {39'd0, busy, done, div_by_zero, quotient, remainder},
        {39'd0, 3'b000, 64'd0});
    @(posedge clk); #1;
    rst = 1'b1;
    early = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done || busy) early++;
    end
    chk("no_done_after_reset", 72'(early), 72'd0);
    run_div(32'd1, 32'd1348760118, q, r, dz, lat);
    chk("post_reset_div", {7'd0, dz, q, r, 1'b0}, {7'd0, 1'b0, 32'd0, 32'd1, 1'b0});
    chk("post_reset_lat", 72'(lat), 72'd33);

    // Randomized pairs, biased toward small and boundary magnitudes.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, b;
      int mode;
      mode = $urandom_range(0, 3);
      a = $urandom; b = $urandom;
      case (mode)
        1: b = 32'($signed($urandom_range(0, 40)) - 20);
        2: a = 32'($signed($urandom_range(0, 40)) - 20);
        3: begin a = 32'(signed'(a[15:0])); b = 32'(signed'(b[15:0])); end
        default: ;
      endcase
      if (n % 97 == 5) a = 32'h8000_0000;
      if (b == 32'd0) b = 32'd1;
      model(a, b, eq, er, edz);
      run_div(a, b, q, r, dz, lat);
      chk($sformatf("rand%0d %h/%h", n, a, b), {dz, 7'(lat), q, r}, {edz, 7'd33, eq, er});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
